mbt_pixel_scheduler: RTL and testbench
======================================

# mbt_pixel_scheduler

Frame-level scheduler that sits directly upstream of the Mandelbrot iteration ALU and directly upstream of the frame buffer. It scans a H_RES × V_RES pixel grid in raster order and derives each pixel's complex coordinate c in the 16-bit Q4.11 fixed-point format (1 sign, 4 integer, 11 fraction bits). For each pixel it resets and starts the ALU, waits for its result, and writes the 7-bit iteration count to the frame buffer. One `frame_start` pulse renders one complete frame.

## Interface
- `H_RES`, default 320: pixels per row.
- `V_RES`, default 240: rows per frame.
- `ADDR_W`, default 17: frame-buffer address width; must satisfy 2^ADDR_W ≥ H_RES·V_RES.
- `TIMEOUT`, default 255: maximum WAIT cycles per pixel.
- `clk` input 1: clock. Everything is on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `frame_start` input 1: single-cycle pulse that begins a frame. Accepted only in IDLE.
- `x_min` input 16: Q4.11 real value at column 0. Latched at frame start.
- `y_max` input 16: Q4.11 imaginary value at row 0. Latched at frame start.
- `step` input 16: Q4.11 grid pitch, used for both axes. Latched at frame start.
- `busy` output 1: high from LOAD through DONE inclusive.
- `frame_done` output 1: one-cycle pulse in DONE.
- `timeout_flag` output 1: sticky. Set on any pixel timeout; cleared only by LOAD or `rst`.
- `alu_rst` output 1: ALU reset.
- `alu_start` output 1: ALU start.
- `c_real` output 16: current pixel's real coordinate.
- `c_img` output 16: current pixel's imaginary coordinate.
- `alu_valid` input 1: ALU finished flag, level-sensitive.
- `alu_d_out` input 7: ALU iteration count.
- `fb_we` output 1: frame-buffer write strobe.
- `fb_addr` output ADDR_W: frame-buffer address.
- `fb_data` output 7: frame-buffer write data.

## Operation
- States: IDLE, LOAD, ARST, START, WAIT, WRITE, DONE.
- IDLE → LOAD on `frame_start`.
- LOAD:
  - latch `x_min`, `y_max`, `step`
  - col=0, row=0, addr=0
  - `c_real`=x_min, `c_img`=y_max
  - clear `timeout_flag` and the wait counter
  - → ARST
- ARST: `alu_rst`=1 for exactly one cycle. → START.
- START: `alu_start`=1 for exactly one cycle; clear the wait counter. → WAIT.
- WAIT: each cycle, sample `alu_valid`.
  - If 1: capture `alu_d_out` into `fb_data`. → WRITE.
  - Else, if wait counter == TIMEOUT−1: `fb_data`=7'd99, set `timeout_flag`. → WRITE.
  - Otherwise increment the wait counter and stay in WAIT.
- WRITE: `fb_we`=1 for one cycle, with `fb_addr`=addr. Then advance:
  - If col < H_RES−1: col+1, addr+1, `c_real` += step. → ARST.
  - Else if row < V_RES−1: col=0, row+1, addr+1, `c_real`=x_min, `c_img` −= step. → ARST.
  - Else (last pixel): → DONE.
- DONE: `frame_done`=1. → IDLE.
- Arithmetic:
  - `c_real` / `c_img` update incrementally with 16-bit two's-complement add/subtract.
  - Wrap-around is modulo 2^16; no saturation.
  - addr is a counter, not a multiplier.
- `frame_start` is ignored in every state except IDLE.
- `alu_valid` is ignored outside WAIT.
- `c_real` / `c_img` are held constant from ARST through WRITE of a given pixel.

## Timing
- Reset values (all outputs 0): `busy`, `frame_done`, `timeout_flag`, `alu_rst`, `alu_start`, `fb_we`, `fb_addr`, `fb_data`, `c_real`, `c_img`.
- `rst` has priority over all state logic and returns to IDLE.
- `rst` mid-frame: no further `fb_we`, no `frame_done`; latched parameters are discarded.
- Per-pixel cost: 3 + n cycles (ARST, START, n WAIT cycles, WRITE), where 1 ≤ n ≤ TIMEOUT.
- `alu_valid` asserted in the first WAIT cycle gives n=1 (4 cycles per pixel).
- Frame latency: 1 (LOAD) + Σ per-pixel + 1 (DONE) cycles after the `frame_start` sample edge.
- `alu_valid` and timeout in the same cycle: valid wins. Write `alu_d_out`; `timeout_flag` is unchanged.
- `fb_addr` increments only on WRITE exit. The last write is at addr H_RES·V_RES−1.
- `busy` falls in the cycle after DONE.

## Test plan
- Grid scan: H_RES=4, V_RES=2, x_min=16'hF800, y_max=16'h04B0, step=16'h0008, ALU model returning valid after 3 cycles with d_out=addr.
  - Exactly 8 writes, addr 0..7, data 0..7.
  - Pixel 1 c_real=F808; pixel 3 c_real=F818.
  - Pixel 4 c_real=F800, c_img=04A8.
  - One `frame_done` pulse.
- Timeout: TIMEOUT=16, `alu_valid` held 0.
  - Each pixel spends exactly 16 WAIT cycles and writes data 99.
  - `timeout_flag`=1 after the first write and stays 1 until the next LOAD.
- Wrap: x_min=16'h7FF8, step=16'h0008 → pixel 1 c_real=16'h8000 (no saturation).
- Handshake: `alu_rst` and `alu_start` are each one-cycle and consecutive before every WAIT. Valid in the first WAIT cycle → 4 cycles per pixel.
- Reset mid-frame: `rst` during WAIT of pixel 3.
  - All outputs 0 the next cycle; no writes or `frame_done` afterwards.
  - A new `frame_start` restarts at addr 0.
- `frame_start` pulsed during `busy`: ignored. Parameter changes mid-frame do not affect the c values.

Source files
------------

// File: rtl/mbt_pixel_scheduler.sv
// Raster-order pixel scheduler for the Mandelbrot ALU: steps a Q4.11 c coordinate
// across the grid, runs one ALU job per pixel and writes the count to the frame buffer.
`timescale 1ns/1ps
module mbt_pixel_scheduler #(
    parameter int H_RES   = 320,
    parameter int V_RES   = 240,
    parameter int ADDR_W  = 17,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [15:0]       x_min,
    input  logic [15:0]       y_max,
    input  logic [15:0]       step,
    output logic              busy,
    output logic              frame_done,
    output logic              timeout_flag,
    output logic              alu_rst,
    output logic              alu_start,
    output logic [15:0]       c_real,
    output logic [15:0]       c_img,
    input  logic              alu_valid,
    input  logic [6:0]        alu_d_out,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [6:0]        fb_data
);

    localparam int COL_W  = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int ROW_W  = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_RES - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(V_RES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [6:0]        TIMEOUT_CODE = 7'd99;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARST,
        S_START,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [15:0]         x_min_q, x_min_d;
    logic [15:0]         step_q, step_d;
    logic [15:0]         c_real_q, c_real_d;
    logic [15:0]         c_img_q, c_img_d;
    logic [6:0]          fb_data_q, fb_data_d;
    logic                timeout_q, timeout_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            wait_q    <= '0;
            x_min_q   <= '0;
            step_q    <= '0;
            c_real_q  <= '0;
            c_img_q   <= '0;
            fb_data_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            wait_q    <= wait_d;
            x_min_q   <= x_min_d;
            step_q    <= step_d;
            c_real_q  <= c_real_d;
            c_img_q   <= c_img_d;
            fb_data_q <= fb_data_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        addr_d     = addr_q;
        wait_d     = wait_q;
        x_min_d    = x_min_q;
        step_d     = step_q;
        c_real_d   = c_real_q;
        c_img_d    = c_img_q;
        fb_data_d  = fb_data_q;
        timeout_d  = timeout_q;
        busy       = (state_q != S_IDLE);
        frame_done = 1'b0;
        alu_rst    = 1'b0;
        alu_start  = 1'b0;
        fb_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start) state_d = S_LOAD;
            end
            S_LOAD: begin
                x_min_d   = x_min;
                step_d    = step;
                col_d     = '0;
                row_d     = '0;
                addr_d    = '0;
                wait_d    = '0;
                c_real_d  = x_min;
                c_img_d   = y_max;
                timeout_d = 1'b0;
                state_d   = S_ARST;
            end
            S_ARST: begin
                alu_rst = 1'b1;
                state_d = S_START;
            end
            S_START: begin
                alu_start = 1'b1;
                wait_d    = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the last allowed cycle still beats the timeout.
                if (alu_valid) begin
                    fb_data_d = alu_d_out;
                    state_d   = S_WRITE;
                end else if (wait_q == WAIT_LAST) begin
                    fb_data_d = TIMEOUT_CODE;
                    timeout_d = 1'b1;
                    state_d   = S_WRITE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WRITE: begin
                fb_we = 1'b1;
                if (col_q != COL_LAST) begin
                    col_d    = col_q + COL_W'(1);
                    addr_d   = addr_q + ADDR_W'(1);
                    c_real_d = c_real_q + step_q;
                    state_d  = S_ARST;
                end else if (row_q != ROW_LAST) begin
                    col_d    = '0;
                    row_d    = row_q + ROW_W'(1);
                    addr_d   = addr_q + ADDR_W'(1);
                    c_real_d = x_min_q;
                    c_img_d  = c_img_q - step_q;
                    state_d  = S_ARST;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign timeout_flag = timeout_q;
    assign c_real       = c_real_q;
    assign c_img        = c_img_q;
    assign fb_addr      = addr_q;
    assign fb_data      = fb_data_q;

endmodule

// File: tb/tb_mbt_pixel_scheduler.sv
// Directed bench for mbt_pixel_scheduler on a 4x2 grid with a behavioural ALU
// whose result latency is set per scenario (0 = never answers).
`timescale 1ns/1ps
module tb_mbt_pixel_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [15:0] x_min = '0;
    logic [15:0] y_max = '0;
    logic [15:0] step = '0;
    logic        busy, frame_done, timeout_flag, alu_rst, alu_start, fb_we;
    logic [15:0] c_real, c_img;
    logic        alu_valid = 1'b0;
    logic [6:0]  alu_d_out = '0;
    logic [2:0]  fb_addr;
    logic [6:0]  fb_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int alu_delay = 0;

    mbt_pixel_scheduler #(
        .H_RES(4),
        .V_RES(2),
        .ADDR_W(3),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_start(frame_start),
        .x_min(x_min),
        .y_max(y_max),
        .step(step),
        .busy(busy),
        .frame_done(frame_done),
        .timeout_flag(timeout_flag),
        .alu_rst(alu_rst),
        .alu_start(alu_start),
        .c_real(c_real),
        .c_img(c_img),
        .alu_valid(alu_valid),
        .alu_d_out(alu_d_out),
        .fb_we(fb_we),
        .fb_addr(fb_addr),
        .fb_data(fb_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ALU model: answers with a running pixel index alu_delay WAIT cycles after start.
    int   alu_cnt = 0;
    int   pix = 0;
    logic alu_run = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            pix = 0; alu_run = 1'b0; alu_cnt = 0; alu_valid = 1'b0;
        end else if (alu_rst) begin
            alu_run = 1'b0; alu_cnt = 0; alu_valid = 1'b0;
        end else if (alu_start) begin
            alu_run = 1'b1; alu_cnt = 0; alu_d_out = 7'(pix);
            pix = (pix + 1) % 8;
        end else if (alu_run && !alu_valid) begin
            alu_cnt++;
            if (alu_delay != 0 && alu_cnt == alu_delay) alu_valid = 1'b1;
        end
    end

    // Output monitor: logs writes and done pulses, tracks handshake and c stability.
    logic [2:0]  wr_addr [256];
    logic [6:0]  wr_data [256];
    logic [15:0] wr_cr [256];
    logic [15:0] wr_ci [256];
    logic        wr_tf [256];
    int          wr_cyc [256];
    int          done_cyc [64];
    int wr_n = 0, done_n = 0, rst_n = 0, start_n = 0, hs_bad = 0, hold_bad = 0;
    logic        prev_rst = 1'b0;
    logic [15:0] cr_h = '0, ci_h = '0;
    always @(negedge clk) begin
        if (fb_we && wr_n < 256) begin
            wr_addr[wr_n] = fb_addr; wr_data[wr_n] = fb_data;
            wr_cr[wr_n] = c_real; wr_ci[wr_n] = c_img;
            wr_tf[wr_n] = timeout_flag; wr_cyc[wr_n] = cyc;
            wr_n++;
        end
        if (frame_done && done_n < 64) begin
            done_cyc[done_n] = cyc; done_n++;
        end
        if (alu_rst) begin
            rst_n++; cr_h = c_real; ci_h = c_img;
        end
        if (alu_start) begin
            start_n++;
            if (!prev_rst || alu_rst) hs_bad++;
        end
        if (prev_rst && !alu_start) hs_bad++;
        if ((alu_start || fb_we) && (c_real !== cr_h || c_img !== ci_h)) hold_bad++;
        prev_rst = alu_rst;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [15:0] xm, input logic [15:0] ym,
                               input logic [15:0] st, input int d, output int s);
        x_min = xm; y_max = ym; step = st; alu_delay = d;
        frame_start = 1'b1;
        s = cyc;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({busy, frame_done, timeout_flag, alu_rst, alu_start, fb_we} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 000000",
                              {busy, frame_done, timeout_flag, alu_rst, alu_start, fb_we});
        end
        n_cmp++;
        if ({fb_addr, fb_data, c_real, c_img} !== 42'd0) begin
            n_bad++; $display("FAIL reset_data: addr %h data %h cr %h ci %h want all 0",
                              fb_addr, fb_data, c_real, c_img);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        rst = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_priority: busy %b want 0", busy);
        end
    endtask

    task automatic test_grid_scan();
        logic [15:0] exp_cr [8] = '{16'hF800, 16'hF808, 16'hF810, 16'hF818,
                                    16'hF800, 16'hF808, 16'hF810, 16'hF818};
        logic [15:0] exp_ci [8] = '{16'h04B0, 16'h04B0, 16'h04B0, 16'h04B0,
                                    16'h04A8, 16'h04A8, 16'h04A8, 16'h04A8};
        int s;
        int w0 = wr_n, d0 = done_n, r0 = rst_n, s0 = start_n, h0 = hs_bad;
        start_frame(16'hF800, 16'h04B0, 16'h0008, 3, s);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL grid_busy_load: busy %b want 1", busy);
        end
        for (int k = 0; k < 200 && done_n == d0; k++) tick();
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL grid_busy_after_done: busy %b want 0", busy);
        end
        n_cmp++;
        if (done_n - d0 !== 1 || done_cyc[d0] !== s + 50) begin
            n_bad++; $display("FAIL grid_done: count %0d at %0d want 1 at %0d",
                              done_n - d0, done_cyc[d0] - s, 50);
        end
        n_cmp++;
        if (wr_n - w0 !== 8) begin
            n_bad++; $display("FAIL grid_write_count: got %0d want 8", wr_n - w0);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (wr_addr[w0+i] !== 3'(i) || wr_data[w0+i] !== 7'(i)) begin
                n_bad++; $display("FAIL grid_write[%0d]: addr %h data %h want %h %h",
                                  i, wr_addr[w0+i], wr_data[w0+i], i, i);
            end
            n_cmp++;
            if (wr_cr[w0+i] !== exp_cr[i] || wr_ci[w0+i] !== exp_ci[i]) begin
                n_bad++; $display("FAIL grid_coord[%0d]: c %h/%h want %h/%h",
                                  i, wr_cr[w0+i], wr_ci[w0+i], exp_cr[i], exp_ci[i]);
            end
            n_cmp++;
            if (wr_cyc[w0+i] !== s + 7 + 6 * i) begin
                n_bad++; $display("FAIL grid_timing[%0d]: cycle %0d want %0d",
                                  i, wr_cyc[w0+i] - s, 7 + 6 * i);
            end
        end
        n_cmp++;
        if (rst_n - r0 !== 8 || start_n - s0 !== 8 || hs_bad !== h0) begin
            n_bad++; $display("FAIL grid_handshake: rst %0d start %0d bad %0d want 8 8 0",
                              rst_n - r0, start_n - s0, hs_bad - h0);
        end
        n_cmp++;
        if (timeout_flag !== 1'b0) begin
            n_bad++; $display("FAIL grid_timeout_flag: got %b want 0", timeout_flag);
        end
    endtask

    task automatic test_timeout();
        int s;
        int w0 = wr_n, d0 = done_n;
        start_frame(16'h0000, 16'h0000, 16'h0001, 0, s);
        for (int k = 0; k < 400 && done_n == d0; k++) tick();
        tick();
        n_cmp++;
        if (done_n - d0 !== 1 || done_cyc[d0] !== s + 154) begin
            n_bad++; $display("FAIL to_done: count %0d at %0d want 1 at 154",
                              done_n - d0, done_cyc[d0] - s);
        end
        n_cmp++;
        if (wr_n - w0 !== 8) begin
            n_bad++; $display("FAIL to_write_count: got %0d want 8", wr_n - w0);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (wr_data[w0+i] !== 7'd99 || wr_tf[w0+i] !== 1'b1 || wr_addr[w0+i] !== 3'(i)) begin
                n_bad++; $display("FAIL to_write[%0d]: data %0d flag %b addr %h want 99 1 %h",
                                  i, wr_data[w0+i], wr_tf[w0+i], wr_addr[w0+i], i);
            end
            n_cmp++;
            if (wr_cyc[w0+i] !== s + 20 + 19 * i) begin
                n_bad++; $display("FAIL to_timing[%0d]: cycle %0d want %0d",
                                  i, wr_cyc[w0+i] - s, 20 + 19 * i);
            end
        end
        n_cmp++;
        if (timeout_flag !== 1'b1) begin
            n_bad++; $display("FAIL to_flag_sticky: got %b want 1", timeout_flag);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_cr [8] = '{16'h7FF8, 16'h8000, 16'h8008, 16'h8010,
                                    16'h7FF8, 16'h8000, 16'h8008, 16'h8010};
        logic [15:0] exp_ci [8] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                    16'hFFF8, 16'hFFF8, 16'hFFF8, 16'hFFF8};
        int s;
        int w0 = wr_n, d0 = done_n, h0 = hs_bad, hb0 = hold_bad;
        start_frame(16'h7FF8, 16'h0000, 16'h0008, 1, s);
        n_cmp++;
        if (timeout_flag !== 1'b1) begin
            n_bad++; $display("FAIL wrap_flag_in_load: got %b want 1", timeout_flag);
        end
        tick();
        n_cmp++;
        if (timeout_flag !== 1'b0 || alu_rst !== 1'b1 || c_real !== 16'h7FF8) begin
            n_bad++; $display("FAIL wrap_first_arst: flag %b alu_rst %b cr %h want 0 1 7ff8",
                              timeout_flag, alu_rst, c_real);
        end
        for (int k = 0; k < 100 && done_n == d0; k++) tick();
        tick();
        n_cmp++;
        if (done_n - d0 !== 1 || done_cyc[d0] !== s + 34) begin
            n_bad++; $display("FAIL wrap_done: count %0d at %0d want 1 at 34",
                              done_n - d0, done_cyc[d0] - s);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (wr_cr[w0+i] !== exp_cr[i] || wr_ci[w0+i] !== exp_ci[i]) begin
                n_bad++; $display("FAIL wrap_coord[%0d]: c %h/%h want %h/%h",
                                  i, wr_cr[w0+i], wr_ci[w0+i], exp_cr[i], exp_ci[i]);
            end
            n_cmp++;
            if (wr_cyc[w0+i] !== s + 5 + 4 * i || wr_data[w0+i] !== 7'(i)) begin
                n_bad++; $display("FAIL wrap_pixel[%0d]: cycle %0d data %0d want %0d %0d",
                                  i, wr_cyc[w0+i] - s, wr_data[w0+i], 5 + 4 * i, i);
            end
        end
        n_cmp++;
        if (hs_bad !== h0 || hold_bad !== hb0) begin
            n_bad++; $display("FAIL wrap_handshake_hold: bad %0d hold %0d want 0 0",
                              hs_bad - h0, hold_bad - hb0);
        end
    endtask

    task automatic test_midframe_ignore();
        logic [15:0] exp_cr [4] = '{16'h0100, 16'h0110, 16'h0120, 16'h0130};
        logic [15:0] exp_ci [2] = '{16'h0200, 16'h01F0};
        int s;
        int w0 = wr_n, d0 = done_n;
        start_frame(16'h0100, 16'h0200, 16'h0010, 2, s);
        repeat (5) tick();
        x_min = 16'h1234; y_max = 16'h7777; step = 16'h0FFF;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (10) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int k = 0; k < 100 && done_n == d0; k++) tick();
        repeat (20) tick();
        n_cmp++;
        if (done_n - d0 !== 1 || done_cyc[d0] !== s + 42 || busy !== 1'b0) begin
            n_bad++; $display("FAIL mid_done: count %0d at %0d busy %b want 1 at 42 busy 0",
                              done_n - d0, done_cyc[d0] - s, busy);
        end
        n_cmp++;
        if (wr_n - w0 !== 8) begin
            n_bad++; $display("FAIL mid_write_count: got %0d want 8", wr_n - w0);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (wr_cr[w0+i] !== exp_cr[i%4] || wr_ci[w0+i] !== exp_ci[i/4] ||
                wr_cyc[w0+i] !== s + 6 + 5 * i) begin
                n_bad++; $display("FAIL mid_pixel[%0d]: c %h/%h cycle %0d want %h/%h %0d",
                                  i, wr_cr[w0+i], wr_ci[w0+i], wr_cyc[w0+i] - s,
                                  exp_cr[i%4], exp_ci[i/4], 6 + 5 * i);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] exp_cr [4] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
        logic [15:0] exp_ci [2] = '{16'h0000, 16'hFFFF};
        int s;
        int w0 = wr_n, d0 = done_n;
        start_frame(16'h0000, 16'h0000, 16'h0001, 5, s);
        for (int k = 0; k < 100 && wr_n - w0 < 3; k++) tick();
        repeat (3) tick();
        n_cmp++;
        if (busy !== 1'b1 || alu_rst !== 1'b0 || alu_start !== 1'b0 || fb_we !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_in_wait: busy %b rst %b start %b we %b want 1 0 0 0",
                              busy, alu_rst, alu_start, fb_we);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({busy, frame_done, timeout_flag, alu_rst, alu_start, fb_we} !== 6'b0 ||
            {fb_addr, fb_data, c_real, c_img} !== 42'd0) begin
            n_bad++; $display("FAIL rstmid_outputs: ctrl %b addr %h data %h cr %h ci %h want 0",
                              {busy, frame_done, timeout_flag, alu_rst, alu_start, fb_we},
                              fb_addr, fb_data, c_real, c_img);
        end
        rst = 1'b0;
        repeat (60) tick();
        n_cmp++;
        if (wr_n - w0 !== 3 || done_n !== d0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_quiet: writes %0d done %0d busy %b want 3 0 0",
                              wr_n - w0, done_n - d0, busy);
        end
        w0 = wr_n;
        start_frame(16'h0000, 16'h0000, 16'h0001, 1, s);
        for (int k = 0; k < 100 && done_n == d0; k++) tick();
        tick();
        n_cmp++;
        if (done_n - d0 !== 1 || done_cyc[d0] !== s + 34 || wr_n - w0 !== 8) begin
            n_bad++; $display("FAIL restart_done: count %0d at %0d writes %0d want 1 at 34, 8",
                              done_n - d0, done_cyc[d0] - s, wr_n - w0);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (wr_addr[w0+i] !== 3'(i) || wr_data[w0+i] !== 7'(i) ||
                wr_cr[w0+i] !== exp_cr[i%4] || wr_ci[w0+i] !== exp_ci[i/4]) begin
                n_bad++; $display("FAIL restart_pixel[%0d]: addr %h data %h c %h/%h want %h %h %h/%h",
                                  i, wr_addr[w0+i], wr_data[w0+i], wr_cr[w0+i], wr_ci[w0+i],
                                  i, i, exp_cr[i%4], exp_ci[i/4]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_grid_scan();
        test_timeout();
        test_wrap();
        test_midframe_ignore();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
